// File: rtl/adder_stim_gen.sv
// adder_stim_gen: emits 8 fixed corner-case operand vectors, then LFSR-driven random vectors,
// to the n-bit adder under test over a valid/ready handshake.
module adder_stim_gen #(
  parameter int          n           = 128,
  parameter int          num_vectors = 30000,
  parameter logic [31:0] seed        = 32'hACE1_2011
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         ready,
  output logic         valid,
  output logic         cin,
  output logic [n-1:0] a,
  output logic [n-1:0] b,
  output logic [31:0]  vec_idx,
  output logic         done
);

  localparam int          WORDS     = n / 32;
  localparam logic [31:0] SEED_EFF  = (seed == 32'h0) ? 32'h1 : seed;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  // Short runs still emit every corner vector, so the last index is never below 7.
  localparam logic [31:0] LAST_IDX  = (num_vectors < 8) ? 32'd7 : 32'(num_vectors - 1);

  typedef enum logic [1:0] {IDLE, CORNER, RANDOM, DONE} state_t;

  state_t         state_r, next_state_s;
  logic [31:0]    lfsr_r, next_lfsr_s, rnd_lfsr_s;
  logic [31:0]    vec_idx_r, next_vec_idx_s;
  logic [n-1:0]   a_r, b_r, next_a_s, next_b_s, rnd_a_s, rnd_b_s;
  logic           cin_r, next_cin_s, rnd_cin_s;
  logic           valid_r, next_valid_s;
  logic           done_r, next_done_s;
  logic           xfer_s;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    lfsr_step = (s >> 1) ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  // Returns {cin, a, b} for corner vector idx.
  function automatic logic [2*n:0] corner_vec(input logic [2:0] idx);
    logic [n-1:0] ones, zero, alt, msb, one;
    ones = {n{1'b1}};
    zero = {n{1'b0}};
    alt  = {(n/2){2'b01}};
    msb  = {1'b1, {(n-1){1'b0}}};
    one  = {{(n-1){1'b0}}, 1'b1};
    case (idx)
      3'd0:    corner_vec = {1'b0, zero, zero};
      3'd1:    corner_vec = {1'b1, ones, zero};
      3'd2:    corner_vec = {1'b1, ones, ones};
      3'd3:    corner_vec = {1'b1, alt, ~alt};
      3'd4:    corner_vec = {1'b0, msb, msb};
      3'd5:    corner_vec = {1'b0, ones, one};
      3'd6:    corner_vec = {1'b1, zero, zero};
      3'd7:    corner_vec = {1'b0, alt, alt};
      default: corner_vec = {1'b0, zero, zero};
    endcase
  endfunction

  assign xfer_s = valid_r && ready;

  // Unrolled 2*WORDS+1 LFSR steps: a words, then b words, then one step for cin.
  always_comb begin
    logic [31:0] walk_s;
    walk_s  = lfsr_r;
    rnd_a_s = {n{1'b0}};
    rnd_b_s = {n{1'b0}};
    for (int i = 0; i < WORDS; i++) begin
      walk_s              = lfsr_step(walk_s);
      rnd_a_s[32*i +: 32] = walk_s;
    end
    for (int i = 0; i < WORDS; i++) begin
      walk_s              = lfsr_step(walk_s);
      rnd_b_s[32*i +: 32] = walk_s;
    end
    walk_s     = lfsr_step(walk_s);
    rnd_cin_s  = walk_s[0];
    rnd_lfsr_s = walk_s;
  end

  // Next-state and next-output logic of the run sequencer.
  always_comb begin
    next_state_s   = state_r;
    next_valid_s   = valid_r;
    next_done_s    = done_r;
    next_vec_idx_s = vec_idx_r;
    next_lfsr_s    = lfsr_r;
    next_cin_s     = cin_r;
    next_a_s       = a_r;
    next_b_s       = b_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          next_state_s   = CORNER;
          next_valid_s   = 1'b1;
          next_done_s    = 1'b0;
          next_vec_idx_s = 32'd0;
          next_lfsr_s    = SEED_EFF;
          {next_cin_s, next_a_s, next_b_s} = corner_vec(3'd0);
        end else begin
          next_state_s = state_r;
        end
      end
      CORNER, RANDOM: begin
        if (xfer_s && (vec_idx_r == LAST_IDX)) begin
          next_state_s = DONE;
          next_valid_s = 1'b0;
          next_done_s  = 1'b1;
        end else if (xfer_s && ((state_r == RANDOM) || (vec_idx_r[2:0] == 3'd7))) begin
          next_state_s   = RANDOM;
          next_vec_idx_s = vec_idx_r + 32'd1;
          next_lfsr_s    = rnd_lfsr_s;
          next_cin_s     = rnd_cin_s;
          next_a_s       = rnd_a_s;
          next_b_s       = rnd_b_s;
        end else if (xfer_s) begin
          next_vec_idx_s = vec_idx_r + 32'd1;
          {next_cin_s, next_a_s, next_b_s} = corner_vec(vec_idx_r[2:0] + 3'd1);
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, LFSR and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      lfsr_r    <= SEED_EFF;
      vec_idx_r <= 32'd0;
      a_r       <= {n{1'b0}};
      b_r       <= {n{1'b0}};
      cin_r     <= 1'b0;
      valid_r   <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      lfsr_r    <= next_lfsr_s;
      vec_idx_r <= next_vec_idx_s;
      a_r       <= next_a_s;
      b_r       <= next_b_s;
      cin_r     <= next_cin_s;
      valid_r   <= next_valid_s;
      done_r    <= next_done_s;
    end
  end

  assign valid   = valid_r;
  assign cin     = cin_r;
  assign a       = a_r;
  assign b       = b_r;
  assign vec_idx = vec_idx_r;
  assign done    = done_r;

endmodule

// File: doc/adder_stim_gen.md
# adder_stim_gen

Synthesizable stimulus generator that drives operand vectors (`cin`, `a`, `b`) into the n-bit adder under test and the reference adder, replacing file-based stimulus reading for long random regressions. It emits a fixed corner-case phase followed by an LFSR-driven random phase. Vectors are delivered under a valid/ready handshake so downstream comparators and loggers can apply back-pressure. It sits directly upstream of the adder DUV, `ref_adder` and the comparator.

## Interface

- `n`, 128, operand width; multiple of 32, range 32..256
- `num_vectors`, 30000, total vectors per run including the corner phase; must be >= 8
- `seed`, 32'hACE1_2011, LFSR seed; value 0 is replaced by 32'h1
- `clk`  input  1  clock, rising-edge
- `rst_n`  input  1  asynchronous active-low reset
- `start`  input  1  begin a run; honoured in IDLE and DONE only
- `ready`  input  1  consumer accepts the current vector
- `valid`  output  1  `cin`/`a`/`b` hold a vector
- `cin`  output  1  carry-in operand
- `a`  output  n  operand A
- `b`  output  n  operand B
- `vec_idx`  output  32  index of the vector currently presented, 0-based
- `done`  output  1  run complete; held until the next `start`

## Operation

- FSM states: IDLE, CORNER, RANDOM, DONE.
- IDLE -> CORNER on `start`. CORNER -> RANDOM when corner vector 7 is accepted. RANDOM -> DONE when vector `num_vectors-1` is accepted. DONE -> CORNER on `start`. `start` in CORNER or RANDOM is ignored.
- Transfer occurs on a rising edge with `valid && ready`. `vec_idx` increments on each transfer.
- While `valid && !ready`, `cin`/`a`/`b`/`vec_idx` are held stable.
- Corner vectors, as (a, b, cin), where ONES = all ones, ALT = 0101... pattern, MSB = only bit n-1 set:
  - 0: (0, 0, 0)
  - 1: (ONES, 0, 1): full carry chain
  - 2: (ONES, ONES, 1)
  - 3: (ALT, ~ALT, 1)
  - 4: (MSB, MSB, 0)
  - 5: (ONES, 1, 0)
  - 6: (0, 0, 1)
  - 7: (ALT, ALT, 0)
- Random phase:
  - Uses a 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1, shifting right; when bit 0 is 1, XOR the register with mask 32'h8020_0003.
  - Each vector takes K = 2n/32 + 1 LFSR steps, unrolled combinationally.
  - Step outputs fill `a` low word first, then `b` low word first. Bit 0 of the final step gives `cin`.
  - The LFSR register advances by K steps per transfer.
- The LFSR is reloaded with `seed` on reset and on every accepted `start`, so runs are reproducible.
- Requirement `num_vectors >= 8`: if violated, the run still emits all 8 corner vectors and then ends.

## Timing

- Reset values: `valid`=0, `cin`=0, `a`=0, `b`=0, `vec_idx`=0, `done`=0, state IDLE, LFSR=`seed`.
- Reset is asserted asynchronously and released synchronously to `clk`. Reset mid-run aborts immediately to the reset values.
- `start` sampled high in IDLE/DONE: the next cycle has `valid`=1, vector 0, `vec_idx`=0, `done`=0.
- Back-to-back transfers: a new vector is presented the cycle after each transfer, with no bubbles.
- Transfer of the last vector: the next cycle has `valid`=0 and `done`=1. `vec_idx` holds `num_vectors-1`.
- `start` coincident with a transfer of the last vector is ignored, because the state is not yet DONE.
- `ready` high while `valid`=0 has no effect.

## Test plan

- Reset then `start`, `ready`=1, n=128: cycle 1 shows (0, 0, 0) with `vec_idx`=0. Cycle 2 shows a=128'hFFFF...FFFF, b=0, cin=1 with `vec_idx`=1.
- `ready` low for 5 cycles while vector 3 is presented: a=ALT, b=~ALT, cin=1 and `vec_idx`=3 stay stable. Vector 4 (MSB, MSB, 0) appears one cycle after `ready` rises.
- Full run, `num_vectors`=20, `ready`=1:
  - exactly 20 transfers;
  - `done` rises on the cycle after transfer 19 and stays high;
  - `valid`=0 thereafter.
- Two runs with the same seed, restarted from DONE: the random vector 8 values are identical across runs. With `seed`=0, the output matches the `seed`=1 run.
- Assert `rst_n`=0 mid-RANDOM at `vec_idx`=12: outputs go to the reset values asynchronously, before the next edge. After release plus `start`, vector 0 reappears.
- Run `ready` randomly toggled for 30000 vectors against `ref_adder` and the comparator: zero mismatches, and `vec_idx` reaches 29999.
